alu_op_sequencer: RTL and testbench

Parametrised ALU control stage: decodes opcode, funct and rt fields into a registered ALU operation code, and sequences multi-cycle multiplies with a stall handshake. Sits at the ID/EX boundary of the pipelined MIPS datapath. It feeds the ALU and drives the hazard unit's stall input. Unlike the purely combinational decoder, illegal encodings produce a defined code plus a flag, never X.

---
 rtl/alu_ctrl_pkg.sv | 58 +++++
 rtl/alu_op_sequencer_if.sv | 26 ++
 rtl/alu_decode.sv | 57 +++++
 rtl/alu_op_sequencer.sv | 101 ++++++++++
 tb/tb_alu_op_sequencer.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ALU control stage: MIPS opcode/funct fields,
// ALU operation codes and the sequencer state type.
package alu_ctrl_pkg;

  localparam logic [5:0] OPC_RTYPE  = 6'b000000;
  localparam logic [5:0] OPC_REGIMM = 6'b000001;
  localparam logic [5:0] OPC_J      = 6'b000010;
  localparam logic [5:0] OPC_JAL    = 6'b000011;
  localparam logic [5:0] OPC_BEQ    = 6'b000100;
  localparam logic [5:0] OPC_BNE    = 6'b000101;
  localparam logic [5:0] OPC_BLEZ   = 6'b000110;
  localparam logic [5:0] OPC_BGTZ   = 6'b000111;
  localparam logic [5:0] OPC_ADDI   = 6'b001000;
  localparam logic [5:0] OPC_SLTI   = 6'b001010;
  localparam logic [5:0] OPC_SLTIU  = 6'b001011;
  localparam logic [5:0] OPC_ANDI   = 6'b001100;
  localparam logic [5:0] OPC_ORI    = 6'b001101;
  localparam logic [5:0] OPC_XORI   = 6'b001110;
  localparam logic [5:0] OPC_MUL    = 6'b011100;
  localparam logic [5:0] OPC_LB     = 6'b100000;
  localparam logic [5:0] OPC_LH     = 6'b100001;
  localparam logic [5:0] OPC_LW     = 6'b100011;
  localparam logic [5:0] OPC_SB     = 6'b101000;
  localparam logic [5:0] OPC_SH     = 6'b101001;
  localparam logic [5:0] OPC_SW     = 6'b101011;

  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_MUL  = 4'd2;
  localparam logic [3:0] ALU_AND  = 4'd3;
  localparam logic [3:0] ALU_OR   = 4'd4;
  localparam logic [3:0] ALU_NOR  = 4'd5;
  localparam logic [3:0] ALU_XOR  = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SLT  = 4'd9;
  localparam logic [3:0] ALU_SRA  = 4'd10;
  localparam logic [3:0] ALU_SLTU = 4'd11;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    MUL_WAIT = 1'b1
  } state_e;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Instruction-field / ALU-control bundle between the ID stage (master)
// and the ALU op sequencer (slave).
interface alu_op_sequencer_if #(
  parameter int unsigned OP_W = 4
);
  logic            InValid;
  logic [5:0]      Opcode;
  logic [5:0]      Funct;
  logic [4:0]      RtField;
  logic            Flush;
  logic [OP_W-1:0] ALUControl;
  logic            OutValid;
  logic            IsMul;
  logic            Illegal;
  logic            Stall;

  modport master (
    output InValid, Opcode, Funct, RtField, Flush,
    input  ALUControl, OutValid, IsMul, Illegal, Stall
  );

  modport slave (
    input  InValid, Opcode, Funct, RtField, Flush,
    output ALUControl, OutValid, IsMul, Illegal, Stall
  );
endinterface

// File: rtl/alu_decode.sv
// Combinational MIPS opcode/funct/rt decoder producing an ALU op code;
// undecodable encodings yield ALU_ADD with illegal set, never X.
module alu_decode
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned EXT_OPS = 1
) (
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic [4:0] rt_field,
  output logic [3:0] op,
  output logic       is_mul,
  output logic       illegal
);

  always_comb begin
    op      = ALU_ADD;
    is_mul  = 1'b0;
    illegal = 1'b0;
    if (opcode == OPC_RTYPE) begin
      case (funct)
        FN_ADD, FN_JR: op = ALU_ADD;
        FN_SUB:        op = ALU_SUB;
        FN_AND:        op = ALU_AND;
        FN_OR:         op = ALU_OR;
        FN_NOR:        op = ALU_NOR;
        FN_XOR:        op = ALU_XOR;
        FN_SLL:        op = ALU_SLL;
        FN_SRL:        op = ALU_SRL;
        FN_SLT:        op = ALU_SLT;
        FN_SRA:        if (EXT_OPS != 0) op = ALU_SRA;  else illegal = 1'b1;
        FN_SLTU:       if (EXT_OPS != 0) op = ALU_SLTU; else illegal = 1'b1;
        default:       illegal = 1'b1;
      endcase
    end else begin
      case (opcode)
        OPC_ADDI, OPC_LW, OPC_LH, OPC_LB,
        OPC_SW, OPC_SH, OPC_SB, OPC_J, OPC_JAL: op = ALU_ADD;
        OPC_MUL: begin
          op     = ALU_MUL;
          is_mul = 1'b1;
        end
        OPC_BEQ, OPC_BNE, OPC_BLEZ, OPC_BGTZ: op = ALU_SUB;
        // bltz (rt=0) and bgez (rt=1); any other rt is illegal
        OPC_REGIMM: if (rt_field == 5'd0 || rt_field == 5'd1) op = ALU_SUB;
                    else illegal = 1'b1;
        OPC_ANDI:  op = ALU_AND;
        OPC_ORI:   op = ALU_OR;
        OPC_XORI:  op = ALU_XOR;
        OPC_SLTI:  op = ALU_SLT;
        OPC_SLTIU: if (EXT_OPS != 0) op = ALU_SLTU; else illegal = 1'b1;
        default:   illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// ID/EX ALU control stage: registers the decoded op and stalls upstream
// while a multi-cycle multiply occupies EX.
module alu_op_sequencer
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned OP_W       = 4,
  parameter int unsigned MUL_CYCLES = 3,
  parameter int unsigned EXT_OPS    = 1
) (
  input  logic          Clk,
  input  logic          Reset,
  alu_op_sequencer_if.slave bus
);

  localparam logic [3:0] CNT_LOAD = 4'(MUL_CYCLES - 1);

  logic [3:0]      dec_op;
  logic            dec_is_mul;
  logic            dec_illegal;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [OP_W-1:0] alu_ctrl_q, alu_ctrl_d;
  logic            out_valid_q, out_valid_d;
  logic            is_mul_q, is_mul_d;
  logic            illegal_q, illegal_d;

  alu_decode #(.EXT_OPS(EXT_OPS)) u_decode (
    .opcode   (bus.Opcode),
    .funct    (bus.Funct),
    .rt_field (bus.RtField),
    .op       (dec_op),
    .is_mul   (dec_is_mul),
    .illegal  (dec_illegal)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    alu_ctrl_d  = alu_ctrl_q;
    out_valid_d = out_valid_q;
    is_mul_d    = is_mul_q;
    illegal_d   = illegal_q;
    if (bus.Flush) begin
      state_d     = IDLE;
      cnt_d       = '0;
      alu_ctrl_d  = '0;
      out_valid_d = 1'b0;
      is_mul_d    = 1'b0;
      illegal_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.InValid) begin
            alu_ctrl_d  = OP_W'(dec_op);
            out_valid_d = 1'b1;
            is_mul_d    = dec_is_mul;
            illegal_d   = dec_illegal;
            if (dec_is_mul && (MUL_CYCLES > 1)) begin
              state_d = MUL_WAIT;
              cnt_d   = CNT_LOAD;
            end
          end else begin
            out_valid_d = 1'b0;
          end
        end
        MUL_WAIT: begin
          // Exit on cnt==1 leaves cnt at 0, so it can never wrap.
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      alu_ctrl_q  <= '0;
      out_valid_q <= 1'b0;
      is_mul_q    <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      alu_ctrl_q  <= alu_ctrl_d;
      out_valid_q <= out_valid_d;
      is_mul_q    <= is_mul_d;
      illegal_q   <= illegal_d;
    end
  end

  assign bus.ALUControl = alu_ctrl_q;
  assign bus.OutValid   = out_valid_q;
  assign bus.IsMul      = is_mul_q;
  assign bus.Illegal    = illegal_q;
  assign bus.Stall      = (state_q == MUL_WAIT);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Drives three sequencer configurations with the same directed + random
// instruction stream and compares each against a cycle-budget model.
module tb_alu_op_sequencer;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       in_valid, flush;
  logic [5:0] opcode, funct;
  logic [4:0] rt_v;

  always #5 Clk = ~Clk;

  alu_op_sequencer_if #(.OP_W(4)) bus0 ();
  alu_op_sequencer_if #(.OP_W(4)) bus1 ();
  alu_op_sequencer_if #(.OP_W(6)) bus2 ();

  assign bus0.InValid = in_valid; assign bus0.Flush = flush;
  assign bus0.Opcode  = opcode;   assign bus0.Funct = funct; assign bus0.RtField = rt_v;
  assign bus1.InValid = in_valid; assign bus1.Flush = flush;
  assign bus1.Opcode  = opcode;   assign bus1.Funct = funct; assign bus1.RtField = rt_v;
  assign bus2.InValid = in_valid; assign bus2.Flush = flush;
  assign bus2.Opcode  = opcode;   assign bus2.Funct = funct; assign bus2.RtField = rt_v;

  alu_op_sequencer #(.OP_W(4), .MUL_CYCLES(3), .EXT_OPS(1)) dut0 (
    .Clk(Clk), .Reset(Reset), .bus(bus0.slave));
  alu_op_sequencer #(.OP_W(4), .MUL_CYCLES(2), .EXT_OPS(0)) dut1 (
    .Clk(Clk), .Reset(Reset), .bus(bus1.slave));
  alu_op_sequencer #(.OP_W(6), .MUL_CYCLES(1), .EXT_OPS(1)) dut2 (
    .Clk(Clk), .Reset(Reset), .bus(bus2.slave));

  logic [5:0] alu_o [3];
  logic       val_o [3], mul_o [3], ill_o [3], stall_o [3];

  assign alu_o[0] = 6'(bus0.ALUControl); assign alu_o[1] = 6'(bus1.ALUControl);
  assign alu_o[2] = bus2.ALUControl;
  assign val_o[0] = bus0.OutValid; assign val_o[1] = bus1.OutValid; assign val_o[2] = bus2.OutValid;
  assign mul_o[0] = bus0.IsMul;    assign mul_o[1] = bus1.IsMul;    assign mul_o[2] = bus2.IsMul;
  assign ill_o[0] = bus0.Illegal;  assign ill_o[1] = bus1.Illegal;  assign ill_o[2] = bus2.Illegal;
  assign stall_o[0] = bus0.Stall;  assign stall_o[1] = bus1.Stall;  assign stall_o[2] = bus2.Stall;

  int mul_cycles [3] = '{3, 2, 1};
  bit ext_ops    [3] = '{1'b1, 1'b0, 1'b1};

  // Model: current output record plus number of stall cycles still owed.
  int m_op [3];
  bit m_valid [3], m_mul [3], m_ill [3], m_op_known [3];
  int m_left [3];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  function automatic void ref_decode(input logic [5:0] oc, input logic [5:0] fn,
                                     input logic [4:0] rt, input bit ext,
                                     output int op, output bit ill);
    op  = 0;
    ill = 1'b0;
    if (oc == 6'h00) begin
      case (fn)
        6'h20, 6'h08: op = 0;
        6'h22: op = 1;
        6'h24: op = 3;
        6'h25: op = 4;
        6'h27: op = 5;
        6'h26: op = 6;
        6'h00: op = 7;
        6'h02: op = 8;
        6'h2A: op = 9;
        6'h03: if (ext) op = 10; else ill = 1'b1;
        6'h2B: if (ext) op = 11; else ill = 1'b1;
        default: ill = 1'b1;
      endcase
    end else begin
      case (oc)
        6'h08, 6'h23, 6'h21, 6'h20, 6'h2B, 6'h29, 6'h28, 6'h02, 6'h03: op = 0;
        6'h1C: op = 2;
        6'h04, 6'h05, 6'h06, 6'h07: op = 1;
        6'h01: if (rt <= 5'd1) op = 1; else ill = 1'b1;
        6'h0C: op = 3;
        6'h0D: op = 4;
        6'h0E: op = 6;
        6'h0A: op = 9;
        6'h0B: if (ext) op = 11; else ill = 1'b1;
        default: ill = 1'b1;
      endcase
    end
  endfunction

  task automatic step(input bit rst, input bit fl, input bit iv,
                      input logic [5:0] oc, input logic [5:0] fn, input logic [4:0] rt);
    int op;
    bit ill;
    Reset = rst; flush = fl; in_valid = iv; opcode = oc; funct = fn; rt_v = rt;
    @(posedge Clk);
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        m_valid[i] = 0; m_op[i] = 0; m_mul[i] = 0; m_ill[i] = 0;
        m_left[i] = 0; m_op_known[i] = 1;
      end else if (fl) begin
        m_valid[i] = 0; m_mul[i] = 0; m_ill[i] = 0; m_left[i] = 0; m_op_known[i] = 0;
      end else if (m_left[i] > 0) begin
        m_left[i]--;
      end else if (iv) begin
        ref_decode(oc, fn, rt, ext_ops[i], op, ill);
        m_op[i] = op; m_ill[i] = ill; m_mul[i] = (oc == 6'h1C);
        m_valid[i] = 1; m_op_known[i] = 1;
        m_left[i] = m_mul[i] ? mul_cycles[i] - 1 : 0;
      end else begin
        m_valid[i] = 0;
      end
    end
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("dut%0d Stall", i), int'(stall_o[i]), int'(m_left[i] > 0));
      check($sformatf("dut%0d OutValid", i), int'(val_o[i]), int'(m_valid[i]));
      check($sformatf("dut%0d IsMul", i), int'(mul_o[i]), int'(m_mul[i]));
      check($sformatf("dut%0d Illegal", i), int'(ill_o[i]), int'(m_ill[i]));
      if (m_op_known[i])
        check($sformatf("dut%0d ALUControl", i), int'(alu_o[i]), m_op[i]);
    end
  endtask

  logic [5:0] opc_pool [25] = '{6'h00, 6'h00, 6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05,
                                6'h06, 6'h07, 6'h08, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E,
                                6'h1C, 6'h1C, 6'h20, 6'h21, 6'h23, 6'h28, 6'h29, 6'h2B, 6'h3F};
  logic [5:0] fn_pool [12] = '{6'h20, 6'h08, 6'h22, 6'h24, 6'h25, 6'h27,
                               6'h26, 6'h00, 6'h02, 6'h2A, 6'h03, 6'h2B};

  initial begin
    logic [5:0] oc, fn;
    logic [4:0] rt;
    // reset, add, mul with input churn during the stall
    step(1, 0, 0, 6'h00, 6'h00, 5'd0);
    step(1, 0, 1, 6'h1C, 6'h20, 5'd0);
    step(0, 0, 1, 6'h00, 6'h20, 5'd0);
    step(0, 0, 1, 6'h1C, 6'h00, 5'd0);
    step(0, 0, 1, 6'h00, 6'h22, 5'd0);
    step(0, 0, 1, 6'h0D, 6'h00, 5'd0);
    step(0, 0, 0, 6'h00, 6'h00, 5'd0);
    // REGIMM legal and illegal rt, sra with/without extension
    step(0, 0, 1, 6'h01, 6'h00, 5'd1);
    step(0, 0, 1, 6'h01, 6'h00, 5'd5);
    step(0, 0, 1, 6'h00, 6'h03, 5'd0);
    step(0, 0, 1, 6'h0B, 6'h00, 5'd0);
    // flush in first stall cycle drops the add presented with it
    step(0, 0, 1, 6'h1C, 6'h00, 5'd0);
    step(0, 1, 1, 6'h00, 6'h20, 5'd0);
    step(0, 0, 0, 6'h00, 6'h20, 5'd0);
    // back-to-back muls, then reset inside the second one
    step(0, 0, 1, 6'h1C, 6'h00, 5'd0);
    step(0, 0, 1, 6'h1C, 6'h00, 5'd0);
    step(0, 0, 1, 6'h1C, 6'h00, 5'd0);
    step(0, 0, 1, 6'h1C, 6'h00, 5'd0);
    step(1, 1, 1, 6'h1C, 6'h00, 5'd0);
    step(0, 0, 0, 6'h00, 6'h00, 5'd0);

    for (int n = 0; n < 3000; n++) begin
      oc = ($urandom_range(0, 7) == 0) ? 6'($urandom) : opc_pool[$urandom_range(0, 24)];
      fn = ($urandom_range(0, 7) == 0) ? 6'($urandom) : fn_pool[$urandom_range(0, 11)];
      rt = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 1));
      step($urandom_range(0, 49) == 0, $urandom_range(0, 24) == 0,
           $urandom_range(0, 3) != 0, oc, fn, rt);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
